// File: rtl/cv32e40p_err_pkg.sv
// Shared constants and types for the cv32e40p fault-event monitor.
package cv32e40p_err_pkg;

   // Bit positions of each error group inside the concatenated error vector
   localparam int ERR_DIV_TMR_BASE    = 0;
   localparam int ERR_MEM_BASE        = 2;
   localparam int ERR_ECC_BASE        = 17;
   localparam int ERR_MULT_BASE       = 20;
   localparam int ERR_NUM_SRC_DEFAULT = 29;

   // Report port states: IDLE looks for pending work, HOLD presents a report
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rpt_state_e;

endpackage

// File: rtl/cv32e40p_err_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr+1 (mod N).
module cv32e40p_err_rr_arb #(
   parameter int N    = 29,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_valid
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             start;
   int             off;
   int             sum;

   // Rotate requests so the search origin sits at bit 0, then take the lowest set bit
   always_comb begin
      start     = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
      dbl       = {req, req} >> start;
      rot       = dbl[N-1:0];
      off       = 0;
      gnt_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         off       = (rot[i] & ~gnt_valid) ? i : off;
         gnt_valid = gnt_valid | rot[i];
      end
      sum    = start + off;
      sum    = (sum >= N) ? sum - N : sum;
      gnt_id = ID_W'(sum);
   end

endmodule

// File: rtl/cv32e40p_err_monitor.sv
// Fault-event monitor: per-channel edge detect, saturating counters, sticky
// flags, threshold alarm and a round-robin valid/ready report port.
module cv32e40p_err_monitor
   import cv32e40p_err_pkg::*;
#(
   parameter int NUM_SRC = ERR_NUM_SRC_DEFAULT,
   parameter int CNT_W   = 8,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_SRC-1:0] err_i,
   input  logic [NUM_SRC-1:0] mask_i,
   input  logic [CNT_W-1:0]   thresh_i,
   input  logic               clr_valid_i,
   input  logic [ID_W-1:0]    clr_id_i,
   input  logic               clr_all_i,
   output logic [NUM_SRC-1:0] sticky_o,
   output logic               alarm_o,
   output logic               rpt_valid_o,
   input  logic               rpt_ready_i,
   output logic [ID_W-1:0]    rpt_id_o,
   output logic [CNT_W-1:0]   rpt_cnt_o
);

   logic [NUM_SRC-1:0] err_q;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] evt;
   logic [NUM_SRC-1:0] clr_hit;
   logic [CNT_W-1:0]   cnt [NUM_SRC];
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_valid;
   logic               launch;
   logic               alarm_next;
   rpt_state_e         state;
   rpt_state_e         state_next;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Rising-edge events on unmasked channels and per-channel clear hits
   always_comb begin
      evt     = err_i & ~err_q & ~mask_i;
      clr_hit = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         clr_hit[i] = clr_all_i | (clr_valid_i & (clr_id_i == ID_W'(i)));
      end
   end

   // Alarm condition from the current counters, mask and threshold
   always_comb begin
      alarm_next = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         alarm_next = alarm_next | (~mask_i[i] & (thresh_i != {CNT_W{1'b0}}) &
                                    (cnt[i] >= thresh_i));
      end
   end

   cv32e40p_err_rr_arb #(
      .N    (NUM_SRC),
      .ID_W (ID_W)
   ) u_arb (
      .req       (pend),
      .ptr       (ptr),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   // Report port next-state: launch from IDLE when work is pending, leave HOLD on handshake
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               launch     = 1'b1;
               state_next = HOLD;
            end else begin
               state_next = IDLE;
            end
         end
         HOLD: begin
            if (rpt_ready_i) begin
               state_next = IDLE;
            end else begin
               state_next = HOLD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Report port registers; id/count are captured only at launch so they stay stable in HOLD
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= IDLE;
         rpt_valid_o <= 1'b0;
         rpt_id_o    <= {ID_W{1'b0}};
         rpt_cnt_o   <= {CNT_W{1'b0}};
         ptr         <= {ID_W{1'b0}};
      end else begin
         state       <= state_next;
         rpt_valid_o <= (state_next == HOLD);
         if (launch) begin
            rpt_id_o  <= gnt_id;
            rpt_cnt_o <= cnt[gnt_id];
            ptr       <= gnt_id;
         end
      end
   end

   // Per-channel state: an event beats a clear, a clear beats the launch acknowledgement
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q    <= {NUM_SRC{1'b0}};
         sticky_o <= {NUM_SRC{1'b0}};
         pend     <= {NUM_SRC{1'b0}};
         alarm_o  <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt[i] <= {CNT_W{1'b0}};
         end
      end else begin
         err_q   <= err_i;
         alarm_o <= alarm_next;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (evt[i]) begin
               cnt[i]      <= clr_hit[i] ? CNT_W'(1) : sat_inc(cnt[i]);
               sticky_o[i] <= 1'b1;
               pend[i]     <= 1'b1;
            end else if (clr_hit[i]) begin
               cnt[i]      <= {CNT_W{1'b0}};
               sticky_o[i] <= 1'b0;
               pend[i]     <= 1'b0;
            end else if (launch && (gnt_id == ID_W'(i))) begin
               pend[i]     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/cv32e40p_err_monitor.md
# cv32e40p_err_monitor

Parametrised fault-event monitor that sits beside `cv32e40p_top` and consumes the concatenated TMR/ECC/memory error flags the core exports. It has one channel per error source. Each channel does rising-edge detection, keeps a saturating event counter and a sticky flag, and has a threshold alarm. Pending events are serialised through a round-robin valid/ready report port to a system error-handling agent. The source count and counter width are parameters, and clearing is per channel, so the block scales with future core hardening variants.

## Interface
Parameters:
- `NUM_SRC`, default 29: number of error channels; the default is 2 div-TMR + 15 mem + 3 ECC + 9 mult-TMR.
- `CNT_W`, default 8: width of each per-channel event counter.
- `ID_W`, default `$clog2(NUM_SRC)`: channel index width.

Ports (clock and reset first):
- `clk_i`, in, 1: single clock.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `err_i`, in, `NUM_SRC`: raw error levels. Bit order is defined by the package base constants.
- `mask_i`, in, `NUM_SRC`: 1 = channel ignored.
- `thresh_i`, in, `CNT_W`: alarm threshold. 0 disables the alarm.
- `clr_valid_i`, in, 1: clear one channel this cycle.
- `clr_id_i`, in, `ID_W`: channel to clear.
- `clr_all_i`, in, 1: clear all channels. Takes priority over `clr_valid_i`.
- `sticky_o`, out, `NUM_SRC`: per-channel "seen since clear" flags.
- `alarm_o`, out, 1: some unmasked channel's counter is at or above `thresh_i`.
- `rpt_valid_o`, out, 1: event report available.
- `rpt_ready_i`, in, 1: consumer accepts the report.
- `rpt_id_o`, out, `ID_W`: reported channel.
- `rpt_cnt_o`, out, `CNT_W`: that channel's counter value at launch.

## Operation
- **Edge detect:** `err_q` registers `err_i` every cycle, including for masked channels. An event on channel i is `err_i[i] & ~err_q[i] & ~mask_i[i]`.
- **Effect of an event:**
  - `cnt[i]` increments, saturating at `2^CNT_W-1`. It never wraps.
  - `sticky[i]` sets to 1.
  - `pend[i]` sets to 1.
- **Clear** (`clr_all_i`, or `clr_valid_i` with matching `clr_id_i`): zeroes `cnt[i]`, `sticky[i]` and `pend[i]`. A `clr_id_i` ≥ `NUM_SRC` is ignored.
- **Clear and event on the same channel in the same cycle:** the event wins over the clear. Result: cnt=1, sticky=1, pend=1.
- **Report port:**
  - It has two states, IDLE and HOLD.
  - IDLE: if any `pend` bit is set, the round-robin arbiter selects channel k. Search starts at (last granted + 1) mod `NUM_SRC`. The port then registers `rpt_id_o`=k and `rpt_cnt_o`=`cnt[k]`, clears `pend[k]`, sets `rpt_valid_o` and moves to HOLD.
  - HOLD: id and count stay stable until `rpt_valid_o & rpt_ready_i`. A new event on k during HOLD re-sets `pend[k]`. On handshake the port returns to IDLE and `rpt_valid_o` drops for one cycle. Back-to-back reports are therefore every 2 cycles.
  - Clearing the channel currently held does not retract `rpt_valid_o` or alter the held data.
- **Alarm:** `alarm_o` is registered and equals the OR over i of (`~mask_i[i]` & `thresh_i`≠0 & `cnt[i]` ≥ `thresh_i`).
- **Reset values:** all outputs 0, and `cnt`, `sticky`, `pend`, `err_q` and the arbiter pointer are all 0. With `err_q`=0 after reset, a source held high through reset counts as exactly one event in the first cycle after reset.
- **Reset mid-HOLD:** the report is dropped and `rpt_valid_o` is 0 the next cycle.

## Timing
- An edge on `err_i` sampled at cycle N makes `cnt`, `sticky_o` and `pend` visible at N+1.
- `rpt_valid_o` rises at the earliest at N+2.
- `alarm_o` rises at N+2 relative to the edge that reaches the threshold.
- A level held high counts once. The same channel can produce a new event no sooner than 2 cycles later (low then high).
- Clear takes effect at the next edge. The cleared values are visible at N+1.
- Changing `mask_i` or `thresh_i` affects `alarm_o` one cycle later.

## Structure
- **Package `cv32e40p_err_pkg`:**
  - Constants `ERR_DIV_TMR_BASE`=0, `ERR_MEM_BASE`=2, `ERR_ECC_BASE`=17, `ERR_MULT_BASE`=20, `ERR_NUM_SRC_DEFAULT`=29.
  - The `rpt_state_e` enum {IDLE, HOLD}.
- **Sub-module `cv32e40p_err_rr_arb`:** combinational round-robin pick. Parameter `N`; inputs `req[N]` and `ptr`; outputs `gnt_id` and `gnt_valid`. The pointer register lives in the parent and updates only on launch.
- **Top-level integration:** `err_i` is `{tmr_mult_err_o, ecc_err_o, mem_err_o, div_tmr_err_o}`, with LSB = div.

## Test plan
- **Reset and held error:** hold `err_i[3]`=1 through reset, then release reset. Expect cnt[3]=1 and sticky_o[3]=1 at cycle 1. With `rpt_ready_i`=1, expect a report with id=3, cnt=1 at cycle 2, and no second count while the level stays high.
- **Saturation:** with `CNT_W`=4, pulse channel 0 twenty times. Expect `rpt_cnt_o`/`cnt` stuck at 15 and no wrap.
- **Round-robin and backpressure:** pulse channels 1, 5 and 20 in the same cycle with `rpt_ready_i`=0 for 5 cycles. Expect `rpt_id_o`=1 held stable. After release, expect ids in the order 1, 5, 20, each with cnt=1, one report every 2 cycles.
- **Threshold alarm:** `thresh_i`=3, three pulses on channel 10. Expect `alarm_o`=1 two cycles after the third edge. Then `clr_valid_i` with `clr_id_i`=10: expect `alarm_o`=0 two cycles later. Then `thresh_i`=0 with 3 further events: expect `alarm_o` stays 0.
- **Clear/event collision and masking:**
  - Clear and edge on channel 7 in the same cycle: expect cnt[7]=1 and sticky_o[7]=1.
  - Set `mask_i[8]`=1 and pulse channel 8: expect no count and no report.
  - Unmask channel 8 while `err_i[8]` is still high: expect no event.
- **Reset during HOLD:** assert `rst_ni`=0 while `rpt_valid_o`=1. Expect `rpt_valid_o`, `sticky_o` and all counts at 0 the next cycle.
